// File: rtl/matrix_accel_pkg.sv
// rtl/matrix_accel_pkg.sv - shared bank-state enum and default sizing for the accumulator buffer
package matrix_accel_pkg;

   // Life cycle of one accumulator bank
   typedef enum logic [1:0] {
      BANK_EMPTY = 2'd0,
      BANK_ACCUM = 2'd1,
      BANK_FULL  = 2'd2
   } bank_state_e;

   localparam int unsigned DEF_LANES     = 16;
   localparam int unsigned DEF_ACC_W     = 24;
   localparam int unsigned DEF_MAX_BEATS = 32;

endpackage

// File: rtl/acc_lane_adder.sv
// rtl/acc_lane_adder.sv - one signed lane add, saturating when ACC_PINGPONG_SAT_EN is defined
module acc_lane_adder #(
   parameter int unsigned ACC_W = 24
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             sat
);

`ifdef ACC_PINGPONG_SAT_EN
   logic [ACC_W:0] ext;

   // Sign-extended add; overflow shows as disagreement of the two top bits
   always_comb begin
      ext = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      sat = 1'b0;
      sum = ext[ACC_W-1:0];
      if (ext[ACC_W] != ext[ACC_W-1]) begin
         sat = 1'b1;
         sum = ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   // Plain two's-complement add, wraps modulo 2^ACC_W
   always_comb begin
      sum = a + b;
      sat = 1'b0;
   end
`endif

endmodule

// File: rtl/acc_pingpong_buffer.sv
// rtl/acc_pingpong_buffer.sv - two-bank ping-pong partial-sum accumulator; ACC_PINGPONG_SAT_EN enables lane saturation
module acc_pingpong_buffer
   import matrix_accel_pkg::*;
#(
   parameter  int unsigned LANES     = DEF_LANES,
   parameter  int unsigned ACC_W     = DEF_ACC_W,
   parameter  int unsigned MAX_BEATS = DEF_MAX_BEATS,
   localparam int unsigned CNT_W     = $clog2(MAX_BEATS) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*ACC_W-1:0] in_psum,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*ACC_W-1:0] out_psum,
   output logic [CNT_W-1:0]       out_beats,
   output logic                   out_overrun,
   output logic                   sat_flag
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

   bank_state_e            state_q   [2];
   bank_state_e            state_d   [2];
   logic [LANES*ACC_W-1:0] data_q    [2];
   logic [LANES*ACC_W-1:0] data_d    [2];
   logic [CNT_W-1:0]       count_q   [2];
   logic [CNT_W-1:0]       count_d   [2];
   logic                   overrun_q [2];
   logic                   overrun_d [2];
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic                   sat_q, sat_d;

   logic                   accept;
   logic                   drain;
   logic [LANES*ACC_W-1:0] acc_base;
   logic [LANES*ACC_W-1:0] sum_bus;
   logic [LANES-1:0]       lane_sat;
   logic [CNT_W-1:0]       next_count;

   // Handshake status decoded purely from bank state
   always_comb begin
      in_ready    = (state_q[wr_bank_q] != BANK_FULL);
      out_valid   = (state_q[rd_bank_q] == BANK_FULL);
      out_psum    = data_q[rd_bank_q];
      out_beats   = count_q[rd_bank_q];
      out_overrun = overrun_q[rd_bank_q];
      sat_flag    = sat_q;
      accept      = in_valid && in_ready;
      drain       = out_valid && out_ready;
      // An empty bank adds against zero, which makes the first beat a plain load
      acc_base    = (state_q[wr_bank_q] == BANK_EMPTY) ? '0 : data_q[wr_bank_q];
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      acc_lane_adder #(.ACC_W(ACC_W)) u_lane (
         .a   (acc_base[i*ACC_W +: ACC_W]),
         .b   (in_psum[i*ACC_W +: ACC_W]),
         .sum (sum_bus[i*ACC_W +: ACC_W]),
         .sat (lane_sat[i])
      );
   end

   // Fill and drain act on different banks, so both can update in one cycle
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      count_d    = count_q;
      overrun_d  = overrun_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      sat_d      = sat_q;
      next_count = (state_q[wr_bank_q] == BANK_EMPTY) ? CNT_W'(1) : count_q[wr_bank_q] + CNT_W'(1);

      if (accept) begin
         data_d[wr_bank_q]  = sum_bus;
         count_d[wr_bank_q] = next_count;
         state_d[wr_bank_q] = BANK_ACCUM;
         sat_d              = sat_q | (|lane_sat);
         if (in_last || (next_count == CNT_MAX)) begin
            state_d[wr_bank_q]   = BANK_FULL;
            overrun_d[wr_bank_q] = !in_last;
            wr_bank_d            = !wr_bank_q;
         end
      end

      if (drain) begin
         state_d[rd_bank_q]   = BANK_EMPTY;
         count_d[rd_bank_q]   = '0;
         overrun_d[rd_bank_q] = 1'b0;
         rd_bank_d            = !rd_bank_q;
      end
   end

   // State registers; reset discards any partial or pending tile
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            state_q[b]   <= BANK_EMPTY;
            data_q[b]    <= '0;
            count_q[b]   <= '0;
            overrun_q[b] <= 1'b0;
         end
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         sat_q     <= sat_d;
      end
   end

endmodule

// File: tb/tb_acc_pingpong_buffer.sv
// tb/tb_acc_pingpong_buffer.sv - directed self-checking bench for acc_pingpong_buffer
module tb_acc_pingpong_buffer;

   localparam int LANES = 16;
   localparam int ACC_W = 24;
   localparam int PW    = LANES * ACC_W;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_psum = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [PW-1:0] out_psum;
   logic [5:0]    out_beats;
   logic          out_overrun;
   logic          sat_flag;

   int checks = 0;
   int errors = 0;

   acc_pingpong_buffer u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_psum     (in_psum),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_psum    (out_psum),
      .out_beats   (out_beats),
      .out_overrun (out_overrun),
      .sat_flag    (sat_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] rep(input logic [ACC_W-1:0] v);
      logic [PW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = v;
      return r;
   endfunction

   // Present one beat for exactly one edge; returns #1 after that edge
   task automatic send_beat(input logic [PW-1:0] p, input logic last);
      in_valid = 1'b1;
      in_psum  = p;
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [PW-1:0] v;

   initial begin
      // Reset state
      tick();
      tick();
      rst = 1'b0;
      check("rst_out_valid", PW'(out_valid), PW'(0));
      check("rst_in_ready", PW'(in_ready), PW'(1));
      check("rst_sat_flag", PW'(sat_flag), PW'(0));

      // Four beats of +5 with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_beat(rep(24'd5), 1'b0);
      check("t1_valid_before_last", PW'(out_valid), PW'(0));
      send_beat(rep(24'd5), 1'b1);
      check("t1_valid", PW'(out_valid), PW'(1));
      check("t1_psum", out_psum, rep(24'd20));
      check("t1_beats", PW'(out_beats), PW'(4));
      check("t1_overrun", PW'(out_overrun), PW'(0));
      tick();
      check("t1_drained", PW'(out_valid), PW'(0));
      out_ready = 1'b0;

      // Two 3-beat tiles fill both banks, then drain in order
      for (int i = 0; i < 3; i++) send_beat(rep(24'd1), i == 2);
      for (int i = 0; i < 3; i++) send_beat(rep(24'd2), i == 2);
      check("t2_in_ready_full", PW'(in_ready), PW'(0));
      check("t2_tile0_psum", out_psum, rep(24'd3));
      tick();
      check("t2_tile0_stable", out_psum, rep(24'd3));
      check("t2_beats", PW'(out_beats), PW'(3));
      out_ready = 1'b1;
      tick();
      check("t2_in_ready_back", PW'(in_ready), PW'(1));
      check("t2_tile1_valid", PW'(out_valid), PW'(1));
      check("t2_tile1_psum", out_psum, rep(24'd6));
      tick();
      out_ready = 1'b0;
      check("t2_all_drained", PW'(out_valid), PW'(0));

      // 33 beats without in_last: force-close at 32, 33rd opens the next tile
      for (int i = 0; i < 32; i++) send_beat(rep(24'd1), 1'b0);
      check("t3_valid", PW'(out_valid), PW'(1));
      check("t3_beats", PW'(out_beats), PW'(32));
      check("t3_overrun", PW'(out_overrun), PW'(1));
      check("t3_psum", out_psum, rep(24'd32));
      check("t3_in_ready_33", PW'(in_ready), PW'(1));
      send_beat(rep(24'd1), 1'b0);
      drain_one();
      check("t3_next_open", PW'(out_valid), PW'(0));
      send_beat(rep(24'd7), 1'b1);
      check("t3_next_psum", out_psum, rep(24'd8));
      check("t3_next_beats", PW'(out_beats), PW'(2));
      check("t3_next_overrun", PW'(out_overrun), PW'(0));
      drain_one();

      // Lane 0 positive overflow, lane 1 negative sum
      v = '0;
      v[23:0]  = 24'h7FFFF0;
      v[47:24] = 24'hFFFFFF;
      send_beat(v, 1'b0);
      v[23:0]  = 24'h000020;
      send_beat(v, 1'b1);
`ifdef ACC_PINGPONG_SAT_EN
      check("t4_lane0", PW'(out_psum[23:0]), PW'(24'h7FFFFF));
      check("t4_sat_flag", PW'(sat_flag), PW'(1));
`else
      check("t4_lane0", PW'(out_psum[23:0]), PW'(24'h800010));
      check("t4_sat_flag", PW'(sat_flag), PW'(0));
`endif
      check("t4_lane1", PW'(out_psum[47:24]), PW'(24'hFFFFFE));
      check("t4_lane2", PW'(out_psum[71:48]), PW'(0));
      drain_one();

      // Drain of one bank coincident with close of the other
      send_beat(rep(24'd1), 1'b0);
      send_beat(rep(24'd1), 1'b1);
      send_beat(rep(24'd4), 1'b0);
      check("t5_first_psum", out_psum, rep(24'd2));
      out_ready = 1'b1;
      send_beat(rep(24'd5), 1'b1);
      check("t5_valid_cont", PW'(out_valid), PW'(1));
      check("t5_second_psum", out_psum, rep(24'd9));
      check("t5_second_beats", PW'(out_beats), PW'(2));
      tick();
      out_ready = 1'b0;
      check("t5_drained", PW'(out_valid), PW'(0));

      // Reset with one full bank and one partial tile
      send_beat(rep(24'd3), 1'b0);
      send_beat(rep(24'd3), 1'b1);
      send_beat(rep(24'd1), 1'b0);
      send_beat(rep(24'd1), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_valid", PW'(out_valid), PW'(0));
      check("t6_in_ready", PW'(in_ready), PW'(1));
      check("t6_sat_flag", PW'(sat_flag), PW'(0));
      send_beat(rep(24'd6), 1'b1);
      check("t6_load_psum", out_psum, rep(24'd6));
      check("t6_load_beats", PW'(out_beats), PW'(1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
